// File: rtl/imem_fetch_unit.sv
// Clocked instruction store with a valid/ready fetch port, a registered decoded response and a program-load port.
// Define IMEM_PARITY_EN to store a per-word even-parity bit and to add the parity_inject load input.
module imem_fetch_unit #(
  parameter int ADDR_W        = 32,
  parameter int DEPTH         = 1024,
  parameter int RESET_PC_WORD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_instr,
  output logic [5:0]        resp_opcode,
  output logic [4:0]        resp_rs,
  output logic [4:0]        resp_rt,
  output logic [4:0]        resp_rd,
  output logic [4:0]        resp_shamt,
  output logic [5:0]        resp_funct,
  output logic [15:0]       resp_imm,
  output logic [31:0]       resp_imm_sext,
  output logic [25:0]       resp_jtarget,
  output logic [1:0]        resp_err,
  output logic [ADDR_W-1:0] resp_addr,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
`ifdef IMEM_PARITY_EN
  input  logic              parity_inject,
`endif
  output logic [31:0]       fetch_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] DEPTH_L = 64'(DEPTH);
  localparam logic [IDX_W-1:0] BOOT_IDX =
    IDX_W'((RESET_PC_WORD >= 0 && RESET_PC_WORD < DEPTH) ? RESET_PC_WORD : 0);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] req_word;
  logic [ADDR_W-1:0] prog_word;
  logic              req_in_range;
  logic              prog_in_range;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  prog_idx;
  logic [31:0]       rd_word;
  logic [1:0]        fetch_err;
  logic [31:0]       fetch_instr;
  logic              accept;
  logic              consume;
  logic              boot_idle;
  logic [31:0]       boot_word;

  assign req_word      = req_addr >> 2;
  assign prog_word     = prog_addr >> 2;
  assign req_in_range  = 64'(req_word) < DEPTH_L;
  assign prog_in_range = 64'(prog_word) < DEPTH_L;
  assign req_idx       = req_in_range ? req_word[IDX_W-1:0] : '0;
  assign prog_idx      = prog_in_range ? prog_word[IDX_W-1:0] : '0;

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;
  assign consume   = resp_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (!reset && prog_we && prog_in_range) begin
      mem[prog_idx] <= prog_data;
    end
  end

  assign rd_word   = mem[req_idx];
  assign boot_word = mem[BOOT_IDX];

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];
  logic parity_bad;

  // Stored bit makes data plus parity an even number of ones; inject flips it to force an error.
  always_ff @(posedge clk) begin
    if (!reset && prog_we && prog_in_range) begin
      par_mem[prog_idx] <= (^prog_data) ^ parity_inject;
    end
  end

  assign parity_bad = (^rd_word) != par_mem[req_idx];
`endif

  always_comb begin
    fetch_err = {!req_in_range, req_addr[1] | req_addr[0]};
`ifdef IMEM_PARITY_EN
    if (req_in_range && parity_bad) begin
      fetch_err = 2'b11;
    end
`endif
    fetch_instr = (fetch_err == 2'b00) ? rd_word : 32'h0;
  end

  // Before the first accept after reset, the idle register mirrors the boot word for debug visibility.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_instr <= 32'h0;
      resp_err   <= 2'b00;
      resp_addr  <= '0;
      boot_idle  <= 1'b1;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_instr <= fetch_instr;
      resp_err   <= fetch_err;
      resp_addr  <= req_addr;
      boot_idle  <= 1'b0;
    end else if (consume) begin
      resp_valid <= 1'b0;
    end else if (boot_idle && !resp_valid) begin
      resp_instr <= boot_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= 32'h0;
    end else if (consume) begin
      fetch_cnt <= fetch_cnt + 32'h1;
    end
  end

  assign resp_opcode   = resp_instr[31:26];
  assign resp_rs       = resp_instr[25:21];
  assign resp_rt       = resp_instr[20:16];
  assign resp_rd       = resp_instr[15:11];
  assign resp_shamt    = resp_instr[10:6];
  assign resp_funct    = resp_instr[5:0];
  assign resp_imm      = resp_instr[15:0];
  assign resp_imm_sext = {{16{resp_instr[15]}}, resp_instr[15:0]};
  assign resp_jtarget  = resp_instr[25:0];

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed self-checking bench for imem_fetch_unit: vector table plus hand-written multi-cycle sequences.
// Exercises the parity path as well when IMEM_PARITY_EN is defined.
module tb_imem_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic [5:0]  resp_opcode;
  logic [4:0]  resp_rs;
  logic [4:0]  resp_rt;
  logic [4:0]  resp_rd;
  logic [4:0]  resp_shamt;
  logic [5:0]  resp_funct;
  logic [15:0] resp_imm;
  logic [31:0] resp_imm_sext;
  logic [25:0] resp_jtarget;
  logic [1:0]  resp_err;
  logic [31:0] resp_addr;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic [31:0] fetch_cnt;
`ifdef IMEM_PARITY_EN
  logic        parity_inject;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  err;
  } vec_t;

  vec_t vecs [8];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  imem_fetch_unit #(.ADDR_W(32), .DEPTH(1024), .RESET_PC_WORD(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_instr   (resp_instr),
    .resp_opcode  (resp_opcode),
    .resp_rs      (resp_rs),
    .resp_rt      (resp_rt),
    .resp_rd      (resp_rd),
    .resp_shamt   (resp_shamt),
    .resp_funct   (resp_funct),
    .resp_imm     (resp_imm),
    .resp_imm_sext(resp_imm_sext),
    .resp_jtarget (resp_jtarget),
    .resp_err     (resp_err),
    .resp_addr    (resp_addr),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
`ifdef IMEM_PARITY_EN
    .parity_inject(parity_inject),
`endif
    .fetch_cnt    (fetch_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic rr,
                               input logic we, input logic [31:0] pa, input logic [31:0] pd);
    req_valid  = v;
    req_addr   = a;
    resp_ready = rr;
    prog_we    = we;
    prog_addr  = pa;
    prog_data  = pd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input logic [31:0] pa, input logic [31:0] pd);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, pa, pd);
    tick();
    prog_we = 1'b0;
  endtask

  task automatic checkResp(input string tag, input logic [31:0] instr, input logic [1:0] err,
                           input logic [31:0] addr);
    checkOutput({tag, " valid"}, 32'(resp_valid), 32'h1);
    checkOutput({tag, " instr"}, resp_instr, instr);
    checkOutput({tag, " err"}, 32'(resp_err), 32'(err));
    checkOutput({tag, " addr"}, resp_addr, addr);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0028, 32'h0149_4824, 2'b00};
    vecs[1] = '{32'h0000_002C, 32'h014B_5824, 2'b00};
    vecs[2] = '{32'h0000_0029, 32'h0000_0000, 2'b01};
    vecs[3] = '{32'h0000_1000, 32'h0000_0000, 2'b10};
    vecs[4] = '{32'h0000_1001, 32'h0000_0000, 2'b11};
    vecs[5] = '{32'h0000_0000, 32'h1111_1111, 2'b00};
    vecs[6] = '{32'h0000_0FFC, 32'hCAFE_F00D, 2'b00};
    vecs[7] = '{32'hFFFF_FFFC, 32'h0000_0000, 2'b10};

`ifdef IMEM_PARITY_EN
    parity_inject = 1'b0;
`endif
    reset = 1'b1;
    applyStimulus(1'b1, 32'h28, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput("reset resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("reset fetch_cnt", fetch_cnt, 32'h0);
      checkOutput("reset resp_instr", resp_instr, 32'h0);
      checkOutput("reset resp_err", 32'(resp_err), 32'h0);
      checkOutput("reset resp_addr", resp_addr, 32'h0);
      checkOutput("reset resp_opcode", 32'(resp_opcode), 32'h0);
      checkOutput("reset resp_imm_sext", resp_imm_sext, 32'h0);
    end
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    #1 checkOutput("req_ready after reset", 32'(req_ready), 32'h1);

    loadWord(32'h0000_0000, 32'h1111_1111);
    loadWord(32'h0000_0028, 32'h0149_4824);
    loadWord(32'h0000_002C, 32'h014B_5824);
    loadWord(32'h0000_0030, 32'h0000_1234);
    loadWord(32'h0000_0FFC, 32'hCAFE_F00D);
    loadWord(32'h0000_1000, 32'hDEAD_BEEF);
    checkOutput("boot idle resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("boot idle resp_instr", resp_instr, 32'h1111_1111);

    // Back-to-back fetches, one response per cycle
    applyStimulus(1'b1, 32'h28, 1'b1, 1'b0, 32'h0, 32'h0);
    #1 checkOutput("b2b req_ready 0", 32'(req_ready), 32'h1);
    tick();
    checkResp("b2b first", 32'h0149_4824, 2'b00, 32'h28);
    checkOutput("b2b opcode", 32'(resp_opcode), 32'h0);
    checkOutput("b2b rs", 32'(resp_rs), 32'd10);
    checkOutput("b2b rt", 32'(resp_rt), 32'd9);
    checkOutput("b2b rd", 32'(resp_rd), 32'd9);
    checkOutput("b2b shamt", 32'(resp_shamt), 32'h0);
    checkOutput("b2b funct", 32'(resp_funct), 32'h24);
    checkOutput("b2b imm", 32'(resp_imm), 32'h4824);
    checkOutput("b2b imm_sext", resp_imm_sext, 32'h0000_4824);
    checkOutput("b2b jtarget", 32'(resp_jtarget), 32'h149_4824);
    applyStimulus(1'b1, 32'h2C, 1'b1, 1'b0, 32'h0, 32'h0);
    #1 checkOutput("b2b req_ready 1", 32'(req_ready), 32'h1);
    tick();
    checkResp("b2b second", 32'h014B_5824, 2'b00, 32'h2C);
    checkOutput("b2b fetch_cnt mid", fetch_cnt, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("b2b drain valid", 32'(resp_valid), 32'h0);
    checkOutput("b2b fetch_cnt", fetch_cnt, 32'd2);

    // Back-pressure holds the response and blocks the next request
    applyStimulus(1'b1, 32'h28, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkResp("bp first", 32'h0149_4824, 2'b00, 32'h28);
    applyStimulus(1'b1, 32'h2C, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("bp req_ready", 32'(req_ready), 32'h0);
      checkResp("bp hold", 32'h0149_4824, 2'b00, 32'h28);
      checkOutput("bp hold rd", 32'(resp_rd), 32'd9);
      tick();
    end
    applyStimulus(1'b1, 32'h2C, 1'b1, 1'b0, 32'h0, 32'h0);
    #1 checkOutput("bp release req_ready", 32'(req_ready), 32'h1);
    tick();
    checkResp("bp released", 32'h014B_5824, 2'b00, 32'h2C);
    checkOutput("bp fetch_cnt mid", fetch_cnt, 32'd3);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("bp drain valid", 32'(resp_valid), 32'h0);
    checkOutput("bp fetch_cnt", fetch_cnt, 32'd4);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].addr, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      checkResp($sformatf("vec%0d", i), vecs[i].instr, vecs[i].err, vecs[i].addr);
      checkOutput($sformatf("vec%0d imm_sext", i), resp_imm_sext,
                  {{16{vecs[i].instr[15]}}, vecs[i].instr[15:0]});
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      checkOutput($sformatf("vec%0d drain valid", i), 32'(resp_valid), 32'h0);
    end
    checkOutput("table fetch_cnt", fetch_cnt, 32'd12);

    // Same-cycle load and fetch to one word returns the old contents
    applyStimulus(1'b1, 32'h30, 1'b1, 1'b1, 32'h30, 32'hFFFF_8000);
    tick();
    checkResp("collision old", 32'h0000_1234, 2'b00, 32'h30);
    applyStimulus(1'b1, 32'h30, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    checkResp("collision new", 32'hFFFF_8000, 2'b00, 32'h30);
    checkOutput("collision imm_sext", resp_imm_sext, 32'hFFFF_8000);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("collision fetch_cnt", fetch_cnt, 32'd14);

    // Reset with a response in flight drops it and ignores a concurrent load
    applyStimulus(1'b1, 32'h28, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("midreset pre valid", 32'(resp_valid), 32'h1);
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h2C, 32'h0);
    tick();
    checkOutput("midreset valid", 32'(resp_valid), 32'h0);
    checkOutput("midreset fetch_cnt", fetch_cnt, 32'h0);
    checkOutput("midreset instr", resp_instr, 32'h0);
    reset = 1'b0;
    applyStimulus(1'b1, 32'h2C, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    checkResp("midreset load ignored", 32'h014B_5824, 2'b00, 32'h2C);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("midreset fetch_cnt after", fetch_cnt, 32'd1);

`ifdef IMEM_PARITY_EN
    parity_inject = 1'b1;
    loadWord(32'h30, 32'h1234_5678);
    parity_inject = 1'b0;
    applyStimulus(1'b1, 32'h30, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    checkResp("parity bad", 32'h0, 2'b11, 32'h30);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    loadWord(32'h30, 32'h1234_5678);
    applyStimulus(1'b1, 32'h30, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    checkResp("parity good", 32'h1234_5678, 2'b00, 32'h30);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
